// File: rtl/inst_buffer_pkg.sv
// Constants and small helpers for the fetch-to-dispatch instruction buffer.
`include "sys_defs.svh"

package inst_buffer_pkg;

   localparam int LANES    = `N;
   localparam int SCALAR_W = `NUM_SCALAR_BITS;

   function automatic int sat_min(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/sys_defs.svh
// Shared machine-wide definitions: superscalar width, buffer sizing and the
// packet format passed from fetch to dispatch.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define N               3
`define NUM_SCALAR_BITS $clog2(`N+1)
`define INST_BUFFER_SZ  16
`define XLEN            32

typedef struct packed {
   logic             valid;
   logic [`XLEN-1:0] inst;
   logic [`XLEN-1:0] PC;
   logic [`XLEN-1:0] NPC;
} FETCH_PACKET;

`endif

// File: rtl/inst_buffer.sv
// Multi-ported circular FIFO of fetch packets: up to N in-order writes and
// N oldest-first reads per cycle, flushed by reset or branch-stack restore.
`include "sys_defs.svh"

module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int DEPTH = `INST_BUFFER_SZ
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        restore_valid,
   input  FETCH_PACKET                 inst_buffer_inputs [`N],
   input  logic [`NUM_SCALAR_BITS-1:0] inst_valid,
   output logic [`NUM_SCALAR_BITS-1:0] inst_buffer_spots,
   output FETCH_PACKET                 dispatch_packets [`N],
   output logic [`NUM_SCALAR_BITS-1:0] dispatch_valid,
   input  logic [`NUM_SCALAR_BITS-1:0] num_dispatched
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0]    head_reg, head_next;
   logic [PTR_W-1:0]    tail_reg, tail_next;
   logic [CNT_W-1:0]    count_reg, count_next;
   logic [SCALAR_W-1:0] enq_num, deq_num;
   logic [PTR_W-1:0]    wr_idx [LANES];
   logic [PTR_W-1:0]    rd_idx [LANES];
   FETCH_PACKET         entries [DEPTH];

   // Spots come from registered count only so fetch never sees a same-cycle
   // dequeue; this keeps spots -> inst_valid free of combinational loops.
   always_comb begin
      inst_buffer_spots = SCALAR_W'(sat_min(LANES, DEPTH - int'(count_reg)));
      dispatch_valid    = SCALAR_W'(sat_min(LANES, int'(count_reg)));
      enq_num    = (inst_valid > inst_buffer_spots) ? inst_buffer_spots : inst_valid;
      deq_num    = (num_dispatched > dispatch_valid) ? dispatch_valid : num_dispatched;
      head_next  = head_reg + PTR_W'(deq_num);
      tail_next  = tail_reg + PTR_W'(enq_num);
      count_next = count_reg + CNT_W'(enq_num) - CNT_W'(deq_num);
   end

   always_ff @(posedge clock) begin
      if (!reset || restore_valid) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   // Pointers are log2(DEPTH) wide, so lane offsets wrap past DEPTH-1 for free.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign wr_idx[gi] = tail_reg + PTR_W'(gi);
         assign rd_idx[gi] = head_reg + PTR_W'(gi);
         assign dispatch_packets[gi] = (SCALAR_W'(gi) < dispatch_valid) ?
                                       entries[rd_idx[gi]] : '0;
      end
   endgenerate

   // Storage is never cleared; validity is tracked purely by head/count.
   always_ff @(posedge clock) begin
      if (reset && !restore_valid) begin
         for (int i = 0; i < LANES; i++) begin
            if (SCALAR_W'(i) < enq_num) begin
               entries[wr_idx[i]] <= inst_buffer_inputs[i];
            end
         end
      end
   end

   a_enq_bound : assert property (@(posedge clock) disable iff (!reset)
                                  inst_valid <= inst_buffer_spots);
   a_deq_bound : assert property (@(posedge clock) disable iff (!reset)
                                  num_dispatched <= dispatch_valid);

endmodule
